// File: rtl/id_issue_stage_pkg.sv
// Shared constants for the id issue stage: default geometry, zero register and
// the decoder payload field layout carried opaquely through the stage.
package id_issue_stage_pkg;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned NREG      = 32;
  localparam int unsigned REG_W     = $clog2(NREG);
  localparam int unsigned NWB       = 2;
  localparam int unsigned PAYLOAD_W = 64;
  localparam int unsigned CNT_W     = 2;
  localparam int unsigned BYPASS    = 1;

  localparam logic [REG_W-1:0] ZERO_REG = '0;

  // Payload layout as produced by the decoder; this stage never looks inside it
  localparam int unsigned ALU_TYPE_WIDTH = 5;
  localparam int unsigned ALU_TYPE_LSB   = 0;
  localparam int unsigned SRC_TAG_WIDTH  = 3;
  localparam int unsigned SRC_TAG_LSB    = ALU_TYPE_LSB + ALU_TYPE_WIDTH;
  localparam int unsigned IMM_WIDTH      = 32;
  localparam int unsigned IMM_LSB        = SRC_TAG_LSB + SRC_TAG_WIDTH;
  localparam int unsigned RSVD_WIDTH     = PAYLOAD_W - IMM_LSB - IMM_WIDTH;

  typedef struct packed {
    logic [RSVD_WIDTH-1:0]     rsvd;
    logic [IMM_WIDTH-1:0]      imm;
    logic [SRC_TAG_WIDTH-1:0]  src_tag;
    logic [ALU_TYPE_WIDTH-1:0] alu_type;
  } payload_t;

endpackage

// File: rtl/id_scoreboard.sv
// Per-register pending-write counters with RAW hazard and WAW overflow detection.
module id_scoreboard
  import id_issue_stage_pkg::*;
#(
  parameter int unsigned NREG   = id_issue_stage_pkg::NREG,
  parameter int unsigned REG_W  = id_issue_stage_pkg::REG_W,
  parameter int unsigned NWB    = id_issue_stage_pkg::NWB,
  parameter int unsigned CNT_W  = id_issue_stage_pkg::CNT_W,
  parameter int unsigned BYPASS = id_issue_stage_pkg::BYPASS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [REG_W-1:0]     i_rs1,
  input  logic                 i_rs1_en,
  input  logic [REG_W-1:0]     i_rs2,
  input  logic                 i_rs2_en,
  input  logic [REG_W-1:0]     i_rd,
  input  logic                 i_rd_en,
  input  logic                 i_issue,
  input  logic [NWB-1:0]       i_wb_en,
  input  logic [NWB*REG_W-1:0] i_wb_rd,
  input  logic                 i_kill,
  input  logic [REG_W-1:0]     i_kill_rd,
  output logic                 o_hazard_c,
  output logic                 o_overflow_c
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] r_cnt     [NREG];
  logic [CNT_W-1:0] w_cnt_nxt [NREG];
  logic [NREG-1:0]  w_wb_hit;
  logic             w_byp1;
  logic             w_byp2;
  int               w_net;

  // Which registers some write-back port targets this cycle
  always_comb begin
    w_wb_hit = '0;
    for (int k = 0; k < NWB; k++)
      if (i_wb_en[k]) w_wb_hit[i_wb_rd[k*REG_W +: REG_W]] = 1'b1;
  end

  // Net counter change: +issue, -each wb port, -killed entry, clamped to range
  always_comb begin
    w_net     = 0;
    w_cnt_nxt = '{default: '0};
    for (int r = 1; r < NREG; r++) begin
      w_net = int'(r_cnt[r]);
      if (i_issue && i_rd_en && (i_rd == REG_W'(r))) w_net = w_net + 1;
      for (int k = 0; k < NWB; k++)
        if (i_wb_en[k] && (i_wb_rd[k*REG_W +: REG_W] == REG_W'(r))) w_net = w_net - 1;
      if (i_kill && (i_kill_rd == REG_W'(r))) w_net = w_net - 1;
      if (w_net < 0) w_net = 0;
      else if (w_net > int'(CNT_MAX)) w_net = int'(CNT_MAX);
      w_cnt_nxt[r] = CNT_W'(w_net);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++) r_cnt[r] <= '0;
    end else begin
      for (int r = 0; r < NREG; r++) r_cnt[r] <= w_cnt_nxt[r];
    end
  end

  // A same-cycle write only clears the hazard when it is the last one pending
  always_comb begin
    w_byp1 = (BYPASS != 0) && w_wb_hit[i_rs1] && (r_cnt[i_rs1] == CNT_W'(1));
    w_byp2 = (BYPASS != 0) && w_wb_hit[i_rs2] && (r_cnt[i_rs2] == CNT_W'(1));
    o_hazard_c = (i_rs1_en && (r_cnt[i_rs1] != '0) && !w_byp1) ||
                 (i_rs2_en && (r_cnt[i_rs2] != '0) && !w_byp2);
    o_overflow_c = i_rd_en && (i_rd != REG_W'(ZERO_REG)) &&
                   (r_cnt[i_rd] == CNT_MAX) && !w_wb_hit[i_rd];
  end

endmodule

// File: rtl/id_issue_stage.sv
// Issue stage: register file with multi-port write-back and bypass, scoreboard
// hazard checks, and a valid/ready output register toward id/ex.
module id_issue_stage
  import id_issue_stage_pkg::*;
#(
  parameter int unsigned XLEN      = id_issue_stage_pkg::XLEN,
  parameter int unsigned NREG      = id_issue_stage_pkg::NREG,
  parameter int unsigned REG_W     = id_issue_stage_pkg::REG_W,
  parameter int unsigned NWB       = id_issue_stage_pkg::NWB,
  parameter int unsigned PAYLOAD_W = id_issue_stage_pkg::PAYLOAD_W,
  parameter int unsigned CNT_W     = id_issue_stage_pkg::CNT_W,
  parameter int unsigned BYPASS    = id_issue_stage_pkg::BYPASS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [REG_W-1:0]     in_rs1,
  input  logic [REG_W-1:0]     in_rs2,
  input  logic                 in_rs1_en,
  input  logic                 in_rs2_en,
  input  logic [REG_W-1:0]     in_rd,
  input  logic                 in_rd_en,
  input  logic [PAYLOAD_W-1:0] in_payload,
  input  logic [NWB-1:0]       wb_en,
  input  logic [NWB*REG_W-1:0] wb_rd,
  input  logic [NWB*XLEN-1:0]  wb_data,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [XLEN-1:0]      out_src1,
  output logic [XLEN-1:0]      out_src2,
  output logic [REG_W-1:0]     out_rd,
  output logic                 out_rd_en,
  output logic [PAYLOAD_W-1:0] out_payload,
  output logic                 stall
);

  logic [XLEN-1:0]      r_rf [NREG];
  logic                 r_out_valid;
  logic [XLEN-1:0]      r_out_src1;
  logic [XLEN-1:0]      r_out_src2;
  logic [REG_W-1:0]     r_out_rd;
  logic                 r_out_rd_en;
  logic [PAYLOAD_W-1:0] r_out_payload;

  logic            w_hazard;
  logic            w_overflow;
  logic            w_space;
  logic            w_in_ready;
  logic            w_issue;
  logic            w_kill;
  logic [XLEN-1:0] w_src1;
  logic [XLEN-1:0] w_src2;

  // Operand read; register 0 is never bypassed, highest matching port wins
  function automatic logic [XLEN-1:0] read_opnd(input logic [REG_W-1:0] rs);
    logic [XLEN-1:0] v;
    v = (rs == REG_W'(ZERO_REG)) ? '0 : r_rf[rs];
    if ((BYPASS != 0) && (rs != REG_W'(ZERO_REG)))
      for (int k = 0; k < NWB; k++)
        if (wb_en[k] && (wb_rd[k*REG_W +: REG_W] == rs)) v = wb_data[k*XLEN +: XLEN];
    return v;
  endfunction

  always_comb begin
    w_src1     = read_opnd(in_rs1);
    w_src2     = read_opnd(in_rs2);
    w_space    = !r_out_valid || out_ready;
    w_in_ready = w_space && !w_hazard && !w_overflow && !flush;
    w_issue    = in_valid && w_in_ready;
    w_kill     = flush && r_out_valid && r_out_rd_en && (r_out_rd != REG_W'(ZERO_REG));
  end

  id_scoreboard #(
    .NREG   (NREG),
    .REG_W  (REG_W),
    .NWB    (NWB),
    .CNT_W  (CNT_W),
    .BYPASS (BYPASS)
  ) u_scoreboard (
    .clk          (clk),
    .rst          (rst),
    .i_rs1        (in_rs1),
    .i_rs1_en     (in_rs1_en),
    .i_rs2        (in_rs2),
    .i_rs2_en     (in_rs2_en),
    .i_rd         (in_rd),
    .i_rd_en      (in_rd_en),
    .i_issue      (w_issue),
    .i_wb_en      (wb_en),
    .i_wb_rd      (wb_rd),
    .i_kill       (w_kill),
    .i_kill_rd    (r_out_rd),
    .o_hazard_c   (w_hazard),
    .o_overflow_c (w_overflow)
  );

  // Later ports overwrite earlier ones on the same index
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++) r_rf[r] <= '0;
    end else begin
      for (int k = 0; k < NWB; k++)
        if (wb_en[k] && (wb_rd[k*REG_W +: REG_W] != REG_W'(ZERO_REG)))
          r_rf[wb_rd[k*REG_W +: REG_W]] <= wb_data[k*XLEN +: XLEN];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid   <= 1'b0;
      r_out_src1    <= '0;
      r_out_src2    <= '0;
      r_out_rd      <= '0;
      r_out_rd_en   <= 1'b0;
      r_out_payload <= '0;
    end else if (flush) begin
      r_out_valid <= 1'b0;
    end else if (w_issue) begin
      r_out_valid   <= 1'b1;
      r_out_src1    <= w_src1;
      r_out_src2    <= w_src2;
      r_out_rd      <= in_rd;
      r_out_rd_en   <= in_rd_en;
      r_out_payload <= in_payload;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign in_ready    = w_in_ready;
  assign stall       = in_valid && !w_in_ready;
  assign out_valid   = r_out_valid;
  assign out_src1    = r_out_src1;
  assign out_src2    = r_out_src2;
  assign out_rd      = r_out_rd;
  assign out_rd_en   = r_out_rd_en;
  assign out_payload = r_out_payload;

endmodule
